// File: rtl/ines_rom_writer_pkg.sv
// Purpose: shared definitions for the iNES ROM writer (FSM states, error codes, format constants).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ines_rom_writer_pkg;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_TRAINER = 3'd1,
        ST_PRG     = 3'd2,
        ST_CHR     = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MAGIC    = 2'd1,
        ERR_NO_PRG   = 2'd2,
        ERR_OVERFLOW = 2'd3
    } err_t;

    // "NES" followed by MS-DOS EOF, in stream order.
    localparam logic [31:0] INES_MAGIC    = 32'h4E45_531A;
    localparam int          HDR_LEN       = 16;
    localparam int          TRAINER_LEN   = 512;
    localparam int          PRG_BANK_SIZE = 16384;
    localparam int          CHR_BANK_SIZE = 8192;

endpackage

// File: rtl/rom_wr_fifo.sv
// Purpose: synchronous write-buffer FIFO between the ROM parser and the memory port.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none upstream; a push while full is dropped unless a pop happens in the same cycle.
// Ports: push/push_dat write side, pop read side, head_dat shows the oldest entry, full/empty status.
module rom_wr_fifo #(
    parameter int W     = 30,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal then.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ines_rom_writer.sv
// Purpose: parse an iNES byte stream and turn PRG/CHR payload into addressed memory writes.
// Latency: a payload byte is presented on mem_addr/mem_din the cycle after its din_valid.
// Backpressure: stream cannot stall; writes queue in a FIFO, overflow drops the byte and errors out.
// Ports: din/din_valid stream in; mem_addr/mem_din/mem_req/mem_ack write port; header fields and
//        header_valid/done/error status out.
module ines_rom_writer
    import ines_rom_writer_pkg::*;
#(
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] PRG_BASE   = 22'h000000,
    parameter logic [ADDR_W-1:0] CHR_BASE   = 22'h200000,
    parameter int                FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [7:0]        mapper,
    output logic [7:0]        prg_banks,
    output logic [7:0]        chr_banks,
    output logic              mirroring,
    output logic              battery,
    output logic              four_screen,
    output logic              header_valid,
    output logic              done,
    output logic [1:0]        error
);

    state_t      state, state_nxt;
    logic [21:0] cnt, cnt_nxt;
    logic [3:0]  hdr_idx;
    logic [31:0] magic;
    logic [7:0]  flags6;
    logic [3:0]  flags7_hi;
    logic        hv_nxt;
    logic [1:0]  err_nxt;

    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic              fifo_full, fifo_empty, pop;
    logic              overflow;

    // Byte count of the final payload byte in each region; 255 PRG banks still fit in 22 bits.
    logic [21:0] prg_last, chr_last;
    assign prg_last = {prg_banks, 14'd0} - 22'd1;
    assign chr_last = {1'b0, chr_banks, 13'd0} - 22'd1;

    assign mapper      = {flags7_hi, flags6[7:4]};
    assign mirroring   = flags6[0];
    assign battery     = flags6[1];
    assign four_screen = flags6[3];

    assign mem_req  = !fifo_empty;
    assign pop      = mem_ack && !fifo_empty;
    assign overflow = push && fifo_full && !pop;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hv_nxt    = header_valid;
        err_nxt   = error;
        push      = 1'b0;
        push_addr = PRG_BASE + ADDR_W'(cnt);
        case (state)
            ST_HDR: begin
                // Magic and bank count are already latched by the time the last header byte arrives.
                if (din_valid && hdr_idx == 4'(HDR_LEN - 1)) begin
                    cnt_nxt = '0;
                    if (magic != INES_MAGIC) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_MAGIC;
                    end else if (prg_banks == 8'd0) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_NO_PRG;
                    end else begin
                        hv_nxt    = 1'b1;
                        state_nxt = flags6[2] ? ST_TRAINER : ST_PRG;
                    end
                end
            end
            ST_TRAINER: begin
                if (din_valid) begin
                    if (cnt == 22'(TRAINER_LEN - 1)) begin
                        state_nxt = ST_PRG;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 22'd1;
                    end
                end
            end
            ST_PRG, ST_CHR: begin
                if (din_valid) begin
                    push = 1'b1;
                    if (state == ST_CHR) push_addr = CHR_BASE + ADDR_W'(cnt);
                    if (overflow) begin
                        state_nxt = ST_ERR;
                        err_nxt   = ERR_OVERFLOW;
                    end else if (state == ST_PRG && cnt == prg_last) begin
                        state_nxt = (chr_banks != 8'd0) ? ST_CHR : ST_DONE;
                        cnt_nxt   = '0;
                    end else if (state == ST_CHR && cnt == chr_last) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 22'd1;
                    end
                end
            end
            default: ; // DONE and ERR are terminal until reset
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_HDR;
            cnt          <= '0;
            hdr_idx      <= '0;
            magic        <= '0;
            prg_banks    <= '0;
            chr_banks    <= '0;
            flags6       <= '0;
            flags7_hi    <= '0;
            header_valid <= 1'b0;
            error        <= ERR_NONE;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            header_valid <= hv_nxt;
            error        <= err_nxt;
            done         <= done || (state == ST_DONE && fifo_empty);
            if (state == ST_HDR && din_valid) begin
                hdr_idx <= hdr_idx + 4'd1;
                case (hdr_idx)
                    4'd0, 4'd1, 4'd2, 4'd3: magic <= {magic[23:0], din};
                    4'd4:    prg_banks <= din;
                    4'd5:    chr_banks <= din;
                    4'd6:    flags6    <= din;
                    4'd7:    flags7_hi <= din[7:4];
                    default: ;
                endcase
            end
        end
    end

    rom_wr_fifo #(
        .W     (ADDR_W + 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat ({push_addr, din}),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat ({mem_addr, mem_din})
    );

endmodule
